// File: rtl/scc_sequencer.sv
// Multi-cycle control sequencer for the SCC core: steps each instruction through
// fetch/decode/execute/memory/writeback, with memory wait states and timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | stopped, waiting for run
// FETCH     | instruction fetch, waiting for in_mem_ready
// DECODE    | instruction register holds the new instruction
// EXECUTE   | ALU op, flags update, branch retire
// MEMORY    | data access, waiting for data_ready
// WRITEBACK | register-file write and retire
// HALT      | halt instruction seen, held until reset
// ERROR     | memory timeout, held until reset
module scc_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             in_mem_ready,
  input  logic             data_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             writes_reg,
  input  logic             sets_flags,
  input  logic             branch_taken,
  output logic             in_mem_en,
  output logic             ir_load,
  output logic             flags_en,
  output logic             data_rd_en,
  output logic             data_wr_en,
  output logic             rf_w_enable,
  output logic             rf_w_select,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   wait_inc;
  logic             timed_out;
  logic             mem_op;
  logic             retire;

  assign mem_op    = is_load | is_store;
  assign wait_inc  = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
  // The cycle that would bring the wait count up to TIMEOUT is the last one allowed.
  assign timed_out = (TIMEOUT != 0) && (wait_inc >= (CNT_W + 1)'(TIMEOUT));

  assign state  = cur_state;
  assign halted = (cur_state == HALT);
  assign error  = (cur_state == ERROR);

  always_comb begin
    in_mem_en   = 1'b0;
    ir_load     = 1'b0;
    flags_en    = 1'b0;
    data_rd_en  = 1'b0;
    data_wr_en  = 1'b0;
    rf_w_enable = 1'b0;
    rf_w_select = 1'b0;
    pc_sel      = 1'b0;
    retire      = 1'b0;
    nxt_state   = cur_state;
    case (cur_state)
      IDLE: if (run) nxt_state = FETCH;
      FETCH: begin
        in_mem_en = 1'b1;
        ir_load   = in_mem_ready;
        if (in_mem_ready)   nxt_state = DECODE;
        else if (timed_out) nxt_state = ERROR;
      end
      DECODE: nxt_state = is_halt ? HALT : EXECUTE;
      EXECUTE: begin
        flags_en = sets_flags;
        if (mem_op)          nxt_state = MEMORY;
        else if (writes_reg) nxt_state = WRITEBACK;
        else begin
          retire = 1'b1;
          pc_sel = branch_taken;
        end
      end
      MEMORY: begin
        data_rd_en = is_load;
        data_wr_en = is_store & ~is_load;
        if (data_ready) begin
          if (is_load) nxt_state = WRITEBACK;
          else         retire    = 1'b1;
        end else if (timed_out) begin
          nxt_state = ERROR;
        end
      end
      WRITEBACK: begin
        rf_w_enable = 1'b1;
        rf_w_select = is_load;
        retire      = 1'b1;
      end
      default: ;
    endcase
    if (retire) nxt_state = run ? FETCH : IDLE;
    pc_en = retire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
      wait_cnt  <= '0;
      retired   <= '0;
      err_code  <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if (cur_state == FETCH || cur_state == MEMORY)
        wait_cnt <= wait_inc[CNT_W-1:0];
      if (nxt_state == ERROR && cur_state != ERROR)
        err_code <= (cur_state == FETCH) ? 2'd1 : 2'd2;
      if (retire)
        retired <= retired + RET_W'(1);
    end
  end

endmodule

// File: tb/tb_scc_sequencer.sv
// Bench for scc_sequencer: directed and randomized instructions compared cycle by
// cycle against a phase-level model of the instruction flow.
module tb_scc_sequencer;

  localparam int TO = 4;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          in_mem_ready = 1'b0;
  logic          data_ready = 1'b0;
  logic          is_load = 1'b0;
  logic          is_store = 1'b0;
  logic          is_halt = 1'b0;
  logic          writes_reg = 1'b0;
  logic          sets_flags = 1'b0;
  logic          branch_taken = 1'b0;
  logic          in_mem_en, ir_load, flags_en, data_rd_en, data_wr_en;
  logic          rf_w_enable, rf_w_select, pc_en, pc_sel, halted, error;
  logic [2:0]    state;
  logic [1:0]    err_code;
  logic [RW-1:0] retired;

  always #5 clk = ~clk;

  scc_sequencer #(.TIMEOUT(TO), .RET_W(RW)) dut (
    .clk(clk), .reset(reset), .run(run), .in_mem_ready(in_mem_ready),
    .data_ready(data_ready), .is_load(is_load), .is_store(is_store),
    .is_halt(is_halt), .writes_reg(writes_reg), .sets_flags(sets_flags),
    .branch_taken(branch_taken), .in_mem_en(in_mem_en), .ir_load(ir_load),
    .flags_en(flags_en), .data_rd_en(data_rd_en), .data_wr_en(data_wr_en),
    .rf_w_enable(rf_w_enable), .rf_w_select(rf_w_select), .pc_en(pc_en),
    .pc_sel(pc_sel), .state(state), .halted(halted), .error(error),
    .err_code(err_code), .retired(retired)
  );

  int            ncmp = 0;
  int            nfail = 0;
  logic [RW-1:0] exp_ret = '0;
  logic [1:0]    exp_err = 2'd0;
  bit            idle = 1'b1;
  bit            d_ld, d_st, d_hlt, d_wr, d_sf, d_br;

  // Packed order: in_mem_en ir_load flags_en rd wr rf_we rf_sel pc_en pc_sel
  function automatic logic [8:0] ov(bit imem, bit irl, bit flg, bit rd, bit wr,
                                    bit rfw, bit rfs, bit pc, bit pcs);
    return {imem, irl, flg, rd, wr, rfw, rfs, pc, pcs};
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic [2:0] es, input logic [8:0] eo,
                      input bit rn, input bit mrdy, input bit drdy, input bit rst);
    logic [8:0] got;
    @(negedge clk);
    reset = rst; run = rn; in_mem_ready = mrdy; data_ready = drdy;
    is_load = d_ld; is_store = d_st; is_halt = d_hlt;
    writes_reg = d_wr; sets_flags = d_sf; branch_taken = d_br;
    #1;
    got = {in_mem_en, ir_load, flags_en, data_rd_en, data_wr_en,
           rf_w_enable, rf_w_select, pc_en, pc_sel};
    ncmp++;
    assert (state === es) else begin
      nfail++; $error("FAIL state: got %0d expected %0d at %0t", state, es, $time);
    end
    ncmp++;
    assert (got === eo) else begin
      nfail++; $error("FAIL enables: got %b expected %b at %0t", got, eo, $time);
    end
    ncmp++;
    assert (retired === exp_ret) else begin
      nfail++; $error("FAIL retired: got %0d expected %0d at %0t", retired, exp_ret, $time);
    end
    ncmp++;
    assert ({halted, error} === {es == 3'd6, es == 3'd7}) else begin
      nfail++; $error("FAIL halted/error: got %b%b expected state %0d at %0t",
                      halted, error, es, $time);
    end
    ncmp++;
    assert (err_code === exp_err) else begin
      nfail++; $error("FAIL err_code: got %0d expected %0d at %0t", err_code, exp_err, $time);
    end
  endtask

  task automatic retire_done(input bit ra);
    exp_ret = exp_ret + RW'(1);
    idle = !ra;
  endtask

  // One instruction as phases: fw fetch stalls, dw data stalls, run value at retire.
  task automatic run_instr(input bit ld, input bit st, input bit hlt, input bit wr,
                           input bit sf, input bit br, input int fw, input int dw,
                           input bit ra);
    d_ld = ld; d_st = st; d_hlt = hlt; d_wr = wr; d_sf = sf; d_br = br;
    if (idle) begin
      step(3'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle = 1'b0;
    end
    for (int k = 0; k < fw && k < TO; k++)
      step(3'd1, ov(1,0,0,0,0,0,0,0,0), rnd(), 1'b0, rnd(), 1'b0);
    if (fw >= TO) begin exp_err = 2'd1; return; end
    step(3'd1, ov(1,1,0,0,0,0,0,0,0), rnd(), 1'b1, 1'b0, 1'b0);
    step(3'd2, 9'd0, rnd(), rnd(), 1'b0, 1'b0);
    if (hlt) return;
    if (ld || st) begin
      step(3'd3, ov(0,0,sf,0,0,0,0,0,0), rnd(), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < dw && k < TO; k++)
        step(3'd4, ov(0,0,0,ld,st & ~ld,0,0,0,0), rnd(), rnd(), 1'b0, 1'b0);
      if (dw >= TO) begin exp_err = 2'd2; return; end
      if (ld) begin
        step(3'd4, ov(0,0,0,1,0,0,0,0,0), rnd(), 1'b0, 1'b1, 1'b0);
        step(3'd5, ov(0,0,0,0,0,1,1,1,0), ra, 1'b0, 1'b0, 1'b0);
      end else begin
        step(3'd4, ov(0,0,0,0,1,0,0,1,0), ra, 1'b0, 1'b1, 1'b0);
      end
    end else if (wr) begin
      step(3'd3, ov(0,0,sf,0,0,0,0,0,0), rnd(), 1'b0, 1'b0, 1'b0);
      step(3'd5, ov(0,0,0,0,0,1,0,1,0), ra, 1'b0, 1'b0, 1'b0);
    end else begin
      step(3'd3, ov(0,0,sf,0,0,0,0,1,br), ra, 1'b0, 1'b0, 1'b0);
    end
    retire_done(ra);
  endtask

  task automatic apply_reset(input logic [2:0] cur_es, input logic [8:0] cur_eo);
    step(cur_es, cur_eo, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_ret = '0; exp_err = 2'd0; idle = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cls;
    reset = 1'b1; run = 1'b1;
    repeat (2) @(posedge clk);

    // ALU op with write: IDLE, F, D, E, W
    run_instr(0,0,0,1,1,0, 0,0, 1'b1);
    // Load with three data wait states (ready lands on the timeout boundary)
    run_instr(1,0,0,1,0,0, 0,3, 1'b1);
    // Taken branch, no register write
    run_instr(0,0,0,0,0,1, 0,0, 1'b1);
    // Load and store both set: load wins; run=0 at retire goes to IDLE
    run_instr(1,1,0,0,1,1, 1,1, 1'b0);
    step(3'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      cls = int'($urandom_range(0, 3));
      run_instr(cls == 2 || (cls == 3 && $urandom_range(0, 3) == 0), cls == 3, 1'b0,
                cls == 0 || (cls >= 2 && rnd()), rnd(), rnd(),
                int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                $urandom_range(0, 3) != 0);
    end

    // Reset in the middle of a stalled store
    d_ld = 0; d_st = 1; d_hlt = 0; d_wr = 0; d_sf = 0; d_br = 0;
    if (idle) begin step(3'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0); idle = 1'b0; end
    step(3'd1, ov(1,1,0,0,0,0,0,0,0), 1'b1, 1'b1, 1'b0, 1'b0);
    step(3'd2, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'd3, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3'd4, ov(0,0,0,0,1,0,0,0,0), 1'b1, 1'b0, 1'b0, 1'b0);
    apply_reset(3'd4, ov(0,0,0,0,1,0,0,0,0));
    step(3'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // One instruction retires, then a halt holds with retired unchanged
    run_instr(0,0,0,1,0,0, 0,0, 1'b1);
    run_instr(0,0,1,0,0,0, 1,0, 1'b1);
    repeat (3) step(3'd6, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_reset(3'd6, 9'd0);

    // Fetch timeout: four stalled FETCH cycles then ERROR, held
    run_instr(0,0,0,1,0,0, TO,0, 1'b1);
    repeat (3) step(3'd7, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_reset(3'd7, 9'd0);

    // Data timeout on a load
    run_instr(1,0,0,1,0,0, 0,TO, 1'b1);
    repeat (2) step(3'd7, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    apply_reset(3'd7, 9'd0);
    step(3'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
